fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Dual-wide instruction buffer between the fetch stage and decode. Accepts up to two
//  {instr, predicted, PC} entries per cycle from fetch and presents up to two oldest
//  entries per cycle to decode, in program order. Generates the fetch stall and
//  discards all contents on flush.
// PARAMETERS
//  DEPTH  8   entries; power of 2, >= 4
//  IW     16  instruction width
//  AW     16  PC width
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  rst       in   1   synchronous, active-high reset
//  flush     in   1   synchronous queue clear (branch redirect)
//  in_i1     in   IW  fetch slot 0 instruction
//  in_i2     in   IW  fetch slot 1 instruction
//  in_i1v    in   1   slot 0 valid
//  in_i2v    in   1   slot 1 valid
//  in_i1p    in   1   slot 0 predicted-taken bit
//  in_i2p    in   1   slot 1 predicted-taken bit
//  in_i1pc   in   AW  slot 0 PC
//  in_i2pc   in   AW  slot 1 PC
//  stall     out  1   to fetch; high = this cycle's input is NOT accepted
//  out0_v    out  1   dispatch slot 0 (oldest) valid
//  out0_inst out  IW  slot 0 instruction
//  out0_p    out  1   slot 0 prediction bit
//  out0_pc   out  AW  slot 0 PC
//  out1_v    out  1   dispatch slot 1 (second oldest) valid
//  out1_inst out  IW  slot 1 instruction
//  out1_p    out  1   slot 1 prediction bit
//  out1_pc   out  AW  slot 1 PC
//  out0_rdy  in   1   decode consumes slot 0 this cycle
//  out1_rdy  in   1   decode consumes slot 1; honoured only with out0_rdy
//  count     out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - State: circular storage of DEPTH entries {inst, p, pc}; head, tail ptrs
//    ($clog2(DEPTH) bits, wrap modulo DEPTH); count 0..DEPTH.
//  - stall = (DEPTH - count) < 2. Combinational from registered count only; no path
//    from the in_* or rdy inputs. Fetch holds its outputs while stall is high, so
//    held input is accepted on the first cycle stall is low.
//  - Enqueue (when !stall, !flush, !rst): n_in = in_i1v + in_i2v. Compacting:
//    valid slots are written to tail, tail+1 in order (slot 0 first). A lone valid
//    slot 1 goes to tail. tail += n_in.
//  - Dequeue: n_out = (out0_v & out0_rdy) + (out1_v & out1_rdy & out0_rdy).
//    head += n_out. out1_rdy without out0_rdy consumes nothing.
//  - count_next = count + n_in - n_out; same-cycle enqueue and dequeue both apply,
//    including at count==DEPTH-2 and count==0.
//  - Outputs are combinational reads of head and head+1 (mod DEPTH).
//    out0_v = count>=1; out1_v = count>=2. Data fields are driven 0 when their
//    valid is low.
//  - Latency: an entry enqueued at edge N is visible on out* after edge N. There is
//    no same-cycle bypass; an empty queue shows out0_v=0 in the enqueue cycle.
//  - Order is strictly FIFO across wrap-around; prediction bits and PCs travel
//    unchanged with their instruction.
//  - rst or flush at an edge: head=tail=count=0. Same-cycle enqueue and dequeue are
//    discarded (flush wins). After that edge out0_v=out1_v=0, all out data 0,
//    stall=0.
//  - Reset values: stall=0, out0_v=out1_v=0, out*_inst/p/pc=0, count=0. Storage
//    contents are not reset.
// STRUCTURE
//  - Shared include fetch_defs.vh: IW, AW, and entry field offsets
//    (ENT_W=IW+AW+1, ENT_P, ENT_PC, ENT_INST). Shared with fetch and decode.
//  - Single module, no sub-modules. Storage is a reg array; no memory macro.
// TESTING
//  - Reset, then idle -> stall=0, out0_v=out1_v=0, count=0, all out data 0.
//  - Enqueue {0x1234,pc 0x0000},{0x5678,pc 0x0002}, rdy=0 -> next cycle out0=0x1234
//    pc0, out1=0x5678 pc2, count=2. Then out0_rdy=out1_rdy=1 -> count=0.
//  - Fill with rdy=0, 2 per cycle, DEPTH=8 -> stall rises at count=7 or 8, not before.
//    Input held while stalled is enqueued exactly once when stall drops.
//  - in_i1v=0, in_i2v=1 (0xBEEF, p=1) -> single entry at head: out0_inst=0xBEEF,
//    out0_p=1, count=1.
//  - out1_rdy=1 with out0_rdy=0 at count=3 -> nothing consumed, count stays 3.
//    Enqueue 2 + dequeue 2 for 10 cycles -> count constant, FIFO order kept across
//    pointer wrap.
//  - flush at count=5 with simultaneous enqueue 2 and dequeue 2 -> next cycle count=0,
//    out*_v=0, stall=0. The next enqueued pair appears first.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: field widths and the layout of one queued entry.
package fetch_queue_pkg;

    localparam int IW = 16;               // instruction width
    localparam int AW = 16;               // PC width

    // Entry layout, LSB first: pc, then the predicted-taken bit, then the instruction.
    localparam int ENT_W    = IW + AW + 1;
    localparam int ENT_PC   = 0;
    localparam int ENT_P    = AW;
    localparam int ENT_INST = AW + 1;

    // Packed so that the field offsets above hold for the struct as a whole.
    typedef struct packed {
        logic [IW-1:0] inst;
        logic          p;
        logic [AW-1:0] pc;
    } fq_entry_t;

    function automatic fq_entry_t make_entry(input logic [IW-1:0] inst,
                                             input logic          p,
                                             input logic [AW-1:0] pc);
        fq_entry_t e;
        e.inst = inst;
        e.p    = p;
        e.pc   = pc;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Dual-wide instruction buffer between fetch and decode.
// Up to two entries enter per cycle (compacted, slot 0 first) and up to two oldest
// entries are presented to decode in program order. A flush empties the queue.
//
// Handshake: fetch input is taken on an edge when stall is low; stall depends only on
// registered occupancy, so fetch simply holds its slots until stall drops. Output slot k
// is consumed on an edge when outk_v and outk_rdy are both high; slot 1 additionally
// needs out0_rdy, so decode can never take the second-oldest entry ahead of the oldest.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [IW-1:0]            in_i1,
    input  logic [IW-1:0]            in_i2,
    input  logic                     in_i1v,
    input  logic                     in_i2v,
    input  logic                     in_i1p,
    input  logic                     in_i2p,
    input  logic [AW-1:0]            in_i1pc,
    input  logic [AW-1:0]            in_i2pc,
    output logic                     stall,
    output logic                     out0_v,
    output logic [IW-1:0]            out0_inst,
    output logic                     out0_p,
    output logic [AW-1:0]            out0_pc,
    output logic                     out1_v,
    output logic [IW-1:0]            out1_inst,
    output logic                     out1_p,
    output logic [AW-1:0]            out1_pc,
    input  logic                     out0_rdy,
    input  logic                     out1_rdy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              accept;
    logic [1:0]        n_in;
    logic [1:0]        n_out;
    logic [PW-1:0]     wr_idx1;
    logic [PW-1:0]     head1;
    fq_entry_t         rd0;
    fq_entry_t         rd1;

    // Stall and handshake terms; stall looks only at registered occupancy.
    always_comb begin
        stall   = (count_q >= CW'(DEPTH - 1));
        accept  = !stall && !flush && !rst;
        n_in    = accept ? ({1'b0, in_i1v} + {1'b0, in_i2v}) : 2'd0;
        n_out   = {1'b0, out0_v & out0_rdy} + {1'b0, out1_v & out1_rdy & out0_rdy};
        // A lone valid slot 1 lands at tail; otherwise slot 1 follows slot 0.
        wr_idx1 = tail_q + PW'(in_i1v);
        head1   = head_q + PW'(1);
    end

    // Next-state pointers and occupancy; reset and flush discard everything in flight.
    always_comb begin
        head_d  = head_q + PW'(n_out);
        tail_d  = tail_q + PW'(n_in);
        count_d = count_q + CW'(n_in) - CW'(n_out);
        if (rst || flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are not reset since valid is derived from count.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (in_i1v) mem_q[tail_q]  <= make_entry(in_i1, in_i1p, in_i1pc);
            if (in_i2v) mem_q[wr_idx1] <= make_entry(in_i2, in_i2p, in_i2pc);
        end
    end

    // Dispatch view of the two oldest entries; data forced to zero when not valid.
    always_comb begin
        out0_v    = (count_q >= CW'(1));
        out1_v    = (count_q >= CW'(2));
        rd0       = mem_q[head_q];
        rd1       = mem_q[head1];
        out0_inst = '0;
        out0_p    = 1'b0;
        out0_pc   = '0;
        out1_inst = '0;
        out1_p    = 1'b0;
        out1_pc   = '0;
        if (out0_v) begin
            out0_inst = rd0.inst;
            out0_p    = rd0.p;
            out0_pc   = rd0.pc;
        end
        if (out1_v) begin
            out1_inst = rd1.inst;
            out1_p    = rd1.p;
            out1_pc   = rd1.pc;
        end
        count = count_q;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed stimulus, expected entries queued by the driver,
// checked by a negedge monitor against a FIFO model of the queue.
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int IW    = 16;
    localparam int AW    = 16;
    localparam int EW    = IW + AW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [IW-1:0] in_i1, in_i2;
    logic          in_i1v, in_i2v, in_i1p, in_i2p;
    logic [AW-1:0] in_i1pc, in_i2pc;
    logic          stall;
    logic          out0_v, out0_p, out1_v, out1_p;
    logic [IW-1:0] out0_inst, out1_inst;
    logic [AW-1:0] out0_pc, out1_pc;
    logic          out0_rdy, out1_rdy;
    logic [3:0]    count;

    logic [EW-1:0] exp_q[$];
    int            tests  = 0;
    int            fails  = 0;
    bit            mon_en = 1'b0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_i1(in_i1), .in_i2(in_i2), .in_i1v(in_i1v), .in_i2v(in_i2v),
        .in_i1p(in_i1p), .in_i2p(in_i2p), .in_i1pc(in_i1pc), .in_i2pc(in_i2pc),
        .stall(stall),
        .out0_v(out0_v), .out0_inst(out0_inst), .out0_p(out0_p), .out0_pc(out0_pc),
        .out1_v(out1_v), .out1_inst(out1_inst), .out1_p(out1_p), .out1_pc(out1_pc),
        .out0_rdy(out0_rdy), .out1_rdy(out1_rdy), .count(count)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare DUT view to the model, then retire what decode consumes this cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            sz = exp_q.size();
            chk("count",  64'(count),  64'(sz > DEPTH ? DEPTH : sz));
            chk("out0_v", 64'(out0_v), 64'(sz >= 1));
            chk("out1_v", 64'(out1_v), 64'(sz >= 2));
            chk("stall",  64'(stall),  64'((DEPTH - sz) < 2));
            if (sz >= 1) chk("out0_entry", 64'({out0_inst, out0_p, out0_pc}), 64'(exp_q[0]));
            else         chk("out0_zero",  64'({out0_inst, out0_p, out0_pc}), 64'(0));
            if (sz >= 2) chk("out1_entry", 64'({out1_inst, out1_p, out1_pc}), 64'(exp_q[1]));
            else         chk("out1_zero",  64'({out1_inst, out1_p, out1_pc}), 64'(0));
            if (rst || flush) begin
                exp_q.delete();
            end else begin
                if (out0_rdy && sz >= 1) void'(exp_q.pop_front());
                if (out0_rdy && out1_rdy && sz >= 2) void'(exp_q.pop_front());
            end
        end
    end

    // Driver: apply one cycle of inputs; queue expected entries if the DUT takes them.
    task automatic step(input logic [IW-1:0] a, input logic ap, input logic [AW-1:0] apc, input logic av,
                        input logic [IW-1:0] b, input logic bp, input logic [AW-1:0] bpc, input logic bv,
                        input logic r0, input logic r1, input logic fl, output bit acc);
        in_i1 = a;  in_i1p = ap; in_i1pc = apc; in_i1v = av;
        in_i2 = b;  in_i2p = bp; in_i2pc = bpc; in_i2v = bv;
        out0_rdy = r0; out1_rdy = r1; flush = fl;
        acc = !stall && !fl && !rst;
        @(posedge clk);
        if (acc) begin
            if (av) exp_q.push_back({a, ap, apc});
            if (bv) exp_q.push_back({b, bp, bpc});
        end
        #1;
    endtask

    task automatic idle(input logic r0, input logic r1);
        bit acc;
        step('0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, r0, r1, 1'b0, acc);
    endtask

    // Hold a pair on the inputs until it is accepted (bounded).
    task automatic send_pair(input logic [IW-1:0] a, input logic [AW-1:0] apc,
                             input logic [IW-1:0] b, input logic [AW-1:0] bpc,
                             input logic r0, input logic r1);
        bit acc;
        int n = 0;
        do begin
            step(a, a[0], apc, 1'b1, b, b[0], bpc, 1'b1, r0, r1, 1'b0, acc);
            n++;
        end while (!acc && n < 20);
        chk("send_accept", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (count != 0 && n < 20) begin
            idle(1'b1, 1'b1);
            n++;
        end
        chk("drain_empty", 64'(count), 64'(0));
    endtask

    initial begin
        bit acc;
        rst = 1'b1; flush = 1'b0;
        in_i1 = '0; in_i2 = '0; in_i1v = 0; in_i2v = 0; in_i1p = 0; in_i2p = 0;
        in_i1pc = '0; in_i2pc = '0; out0_rdy = 0; out1_rdy = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(0, 0); idle(0, 0);
        chk("reset_count", 64'(count), 64'(0));
        chk("reset_stall", 64'(stall), 64'(0));

        // Pair in, visible next cycle, then consumed two at once.
        step(16'h1234, 1'b0, 16'h0000, 1'b1, 16'h5678, 1'b0, 16'h0002, 1'b1, 0, 0, 0, acc);
        chk("pair_out0", 64'(out0_inst), 64'h1234);
        chk("pair_out1_pc", 64'(out1_pc), 64'h0002);
        chk("pair_count", 64'(count), 64'd2);
        idle(1, 1);
        chk("pair_drained", 64'(count), 64'd0);

        // Fill two per cycle; held pair after stall goes in exactly once.
        for (int i = 0; i < 4; i++)
            send_pair(16'h1000 + 16'(2*i), 16'(4*i), 16'h1001 + 16'(2*i), 16'(4*i + 2), 0, 0);
        chk("full_count", 64'(count), 64'd8);
        chk("full_stall", 64'(stall), 64'd1);
        step(16'h2000, 1'b1, 16'h0100, 1'b1, 16'h2001, 1'b0, 16'h0102, 1'b1, 1, 1, 0, acc);
        chk("stalled_not_acc", 64'(acc), 64'd0);
        send_pair(16'h2000, 16'h0100, 16'h2001, 16'h0102, 0, 0);
        chk("held_once_count", 64'(count), 64'd8);
        drain();

        // Lone slot 1.
        step('0, 1'b0, '0, 1'b0, 16'hBEEF, 1'b1, 16'h0040, 1'b1, 0, 0, 0, acc);
        chk("lone_inst", 64'(out0_inst), 64'hBEEF);
        chk("lone_p", 64'(out0_p), 64'd1);
        chk("lone_count", 64'(count), 64'd1);

        // out1_rdy alone consumes nothing.
        send_pair(16'h3000, 16'h0200, 16'h3001, 16'h0202, 0, 0);
        idle(0, 1);
        chk("r1_only_count", 64'(count), 64'd3);
        drain();

        // Steady two-in two-out across pointer wrap.
        send_pair(16'h4000, 16'h0300, 16'h4001, 16'h0302, 0, 0);
        for (int i = 0; i < 10; i++) begin
            send_pair(16'h4100 + 16'(2*i), 16'h0400 + 16'(4*i), 16'h4101 + 16'(2*i), 16'h0402 + 16'(4*i), 1, 1);
            chk("steady_count", 64'(count), 64'd2);
        end
        drain();

        // Flush at count 5 with simultaneous enqueue and dequeue.
        send_pair(16'h5000, 16'h0500, 16'h5001, 16'h0502, 0, 0);
        send_pair(16'h5002, 16'h0504, 16'h5003, 16'h0506, 0, 0);
        step(16'h5004, 1'b0, 16'h0508, 1'b1, '0, 1'b0, '0, 1'b0, 0, 0, 0, acc);
        chk("pre_flush_count", 64'(count), 64'd5);
        step(16'h5100, 1'b0, 16'h0600, 1'b1, 16'h5101, 1'b1, 16'h0602, 1'b1, 1, 1, 1, acc);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_v", 64'({out0_v, out1_v}), 64'd0);
        chk("flush_stall", 64'(stall), 64'd0);
        send_pair(16'h6000, 16'h0700, 16'h6001, 16'h0702, 0, 0);
        chk("post_flush_out0", 64'(out0_inst), 64'h6000);
        drain();
        idle(0, 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
